// File: rtl/four_output_demux_if.sv
// Bus bundle for the 1-to-4 demux: producer side, four consumer sides and
// the per-channel delivery counters.
interface four_output_demux_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_select;
  logic              in_broadcast;
  logic [DATA_W-1:0] in_data;
  logic [3:0]        out_valid;
  logic [3:0]        out_ready;
  logic [DATA_W-1:0] out_data0;
  logic [DATA_W-1:0] out_data1;
  logic [DATA_W-1:0] out_data2;
  logic [DATA_W-1:0] out_data3;
  logic [CNT_W-1:0]  deliver_cnt0;
  logic [CNT_W-1:0]  deliver_cnt1;
  logic [CNT_W-1:0]  deliver_cnt2;
  logic [CNT_W-1:0]  deliver_cnt3;

  // Demux side.
  modport slave (
    input  in_valid, in_select, in_broadcast, in_data, out_ready,
    output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3,
    output deliver_cnt0, deliver_cnt1, deliver_cnt2, deliver_cnt3
  );

  // Producer plus consumers side.
  modport master (
    output in_valid, in_select, in_broadcast, in_data, out_ready,
    input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3,
    input  deliver_cnt0, deliver_cnt1, deliver_cnt2, deliver_cnt3
  );
endinterface

// File: rtl/four_output_demux.sv
// Registered 1-to-4 data distributor. Each channel has a one-entry holding
// register with valid/ready; unicast goes to one channel, broadcast to all
// four atomically. Per-channel counters tally completed output handshakes.
module four_output_demux #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input logic               clk,
  input logic               rst_n,
  four_output_demux_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [3:0]        full_q;
  logic [3:0]        full_d;
  logic [3:0]        free;
  logic [3:0]        load;
  logic [3:0]        hs;
  logic              accept;
  logic [DATA_W-1:0] data_q [4];
  logic [CNT_W-1:0]  cnt_q  [4];

  // Handshake decode: a channel is free if empty or draining this cycle, so
  // drain and refill can share an edge. in_ready never looks at in_valid.
  always_comb begin
    free         = ~full_q | bus.out_ready;
    bus.in_ready = bus.in_broadcast ? (&free) : free[bus.in_select];
    accept       = bus.in_valid & bus.in_ready;
    load         = 4'b0000;
    if (accept) begin
      if (bus.in_broadcast) begin
        load = 4'b1111;
      end else begin
        load[bus.in_select] = 1'b1;
      end
    end
    hs     = full_q & bus.out_ready;
    full_d = load | (full_q & ~bus.out_ready);
  end

  // Channel occupancy flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 4'b0000;
    end else begin
      full_q <= full_d;
    end
  end

  // Holding registers load only on accept; they hold through stalls and drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) data_q[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (load[k]) data_q[k] <= bus.in_data;
      end
    end
  end

  // Delivery counters, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (hs[k]) cnt_q[k] <= cnt_q[k] + CNT_ONE;
      end
    end
  end

  // Output mapping.
  always_comb begin
    bus.out_valid    = full_q;
    bus.out_data0    = data_q[0];
    bus.out_data1    = data_q[1];
    bus.out_data2    = data_q[2];
    bus.out_data3    = data_q[3];
    bus.deliver_cnt0 = cnt_q[0];
    bus.deliver_cnt1 = cnt_q[1];
    bus.deliver_cnt2 = cnt_q[2];
    bus.deliver_cnt3 = cnt_q[3];
  end

endmodule
